// File: rtl/mem_bus_port.sv
// Bridge from the cartridge CPU bus to one mapper memory port (ROM or BRAM).
// All state advances on the falling clock edge; rst is asynchronous, active high.
module mem_bus_port #(
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WIN_BIT  = 21,
  parameter int unsigned WIN_VAL  = 0,
  parameter int unsigned WRITABLE = 1,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_ce_n,
  input  logic              cpu_oe_n,
  input  logic              cpu_we_lo_n,
  input  logic              cpu_we_hi_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dati,
  output logic              mem_oe,
  output logic              mem_we_lo,
  output logic              mem_we_hi,
  input  logic [DATA_W-1:0] mem_dato,
  output logic              sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  logic              hit_raw;
  logic              hit_s1, hit_s2;
  logic              rd_s1, rd_s2;
  logic [ADDR_W-1:0] addr_s1, addr_s2;
  logic [1:0]        lat_cnt;

  assign hit_raw = !cpu_ce_n && (cpu_addr[WIN_BIT] == 1'(WIN_VAL));

  // Address travels through the same two stages as the strobes so they line up.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      hit_s1  <= 1'b0;
      hit_s2  <= 1'b0;
      rd_s1   <= 1'b0;
      rd_s2   <= 1'b0;
      addr_s1 <= '0;
      addr_s2 <= '0;
    end else begin
      hit_s1  <= hit_raw;
      hit_s2  <= hit_s1;
      rd_s1   <= !cpu_oe_n;
      rd_s2   <= rd_s1;
      addr_s1 <= cpu_addr;
      addr_s2 <= addr_s1;
    end
  end

  assign sel      = hit_s2 && rd_s2;
  assign mem_oe   = sel;
  assign mem_addr = addr_s2;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (!sel) begin
      lat_cnt  <= '0;
      rd_valid <= 1'b0;
    end else if (!rd_valid) begin
      if (lat_cnt == LAT_LAST) begin
        rd_valid <= 1'b1;
        rd_data  <= mem_dato;
      end else begin
        lat_cnt <= lat_cnt + 2'd1;
      end
    end
  end

  generate
    if (WRITABLE != 0) begin : g_wr
      logic [DATA_W-1:0] data_s1, data_s2;
      logic [2:0]        lo_sr, hi_sr;
      logic              lo_arm, hi_arm;
      logic              lo_fire, hi_fire;
      logic              we_lo_q, we_hi_q;
      logic [DATA_W-1:0] dati_q;

      // arm only sets once the raw strobe is seen released, so a strobe still
      // held low across reset cannot produce a pulse afterwards
      assign lo_fire = (lo_sr == 3'b011) && lo_arm && hit_s2;
      assign hi_fire = (hi_sr == 3'b011) && hi_arm && hit_s2;

      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          data_s1 <= '0;
          data_s2 <= '0;
          lo_sr   <= '0;
          hi_sr   <= '0;
          lo_arm  <= 1'b0;
          hi_arm  <= 1'b0;
          we_lo_q <= 1'b0;
          we_hi_q <= 1'b0;
          dati_q  <= '0;
        end else begin
          data_s1 <= cpu_data;
          data_s2 <= data_s1;
          lo_sr   <= {lo_sr[1:0], !cpu_we_lo_n};
          hi_sr   <= {hi_sr[1:0], !cpu_we_hi_n};
          if (cpu_we_lo_n) lo_arm <= 1'b1;
          if (cpu_we_hi_n) hi_arm <= 1'b1;
          we_lo_q <= lo_fire;
          we_hi_q <= hi_fire;
          if (lo_fire || hi_fire) dati_q <= data_s2;
        end
      end

      assign mem_we_lo = we_lo_q;
      assign mem_we_hi = we_hi_q;
      assign mem_dati  = dati_q;
    end else begin : g_ro
      assign mem_we_lo = 1'b0;
      assign mem_we_hi = 1'b0;
      assign mem_dati  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_bus_port.sv
// Directed bench for a ROM (window 0, read-only, latency 2) and a BRAM
// (window 1, writable, latency 1) port sharing one CPU bus.
module tb_mem_bus_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_ce_n, cpu_oe_n, cpu_we_lo_n, cpu_we_hi_n;

  logic [22:0] rom_mem_addr, ram_mem_addr;
  logic [15:0] rom_mem_dati, ram_mem_dati;
  logic        rom_mem_oe, ram_mem_oe;
  logic        rom_we_lo, rom_we_hi, ram_we_lo, ram_we_hi;
  logic [15:0] rom_dato, ram_dato;
  logic        rom_sel, ram_sel;
  logic [15:0] rom_rd_data, ram_rd_data;
  logic        rom_rd_valid, ram_rd_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned ram_lo_cnt, ram_hi_cnt, ram_both_cnt, rom_pulse_cnt;
  logic [15:0] ram_dati_seen, rom_dati_or;

  always #10 clk = ~clk;

  assign rom_dato = 16'hA55A;
  assign ram_dato = 16'h5AA5;

  mem_bus_port #(.ADDR_W(23), .DATA_W(16), .WIN_BIT(21), .WIN_VAL(0),
                 .WRITABLE(0), .READ_LAT(2)) u_rom (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n),
    .cpu_we_lo_n(cpu_we_lo_n), .cpu_we_hi_n(cpu_we_hi_n),
    .mem_addr(rom_mem_addr), .mem_dati(rom_mem_dati), .mem_oe(rom_mem_oe),
    .mem_we_lo(rom_we_lo), .mem_we_hi(rom_we_hi), .mem_dato(rom_dato),
    .sel(rom_sel), .rd_data(rom_rd_data), .rd_valid(rom_rd_valid));

  mem_bus_port #(.ADDR_W(23), .DATA_W(16), .WIN_BIT(21), .WIN_VAL(1),
                 .WRITABLE(1), .READ_LAT(1)) u_ram (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n),
    .cpu_we_lo_n(cpu_we_lo_n), .cpu_we_hi_n(cpu_we_hi_n),
    .mem_addr(ram_mem_addr), .mem_dati(ram_mem_dati), .mem_oe(ram_mem_oe),
    .mem_we_lo(ram_we_lo), .mem_we_hi(ram_we_hi), .mem_dato(ram_dato),
    .sel(ram_sel), .rd_data(ram_rd_data), .rd_valid(ram_rd_valid));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    ram_lo_cnt = 0; ram_hi_cnt = 0; ram_both_cnt = 0; rom_pulse_cnt = 0;
    ram_dati_seen = '0; rom_dati_or = '0;
  endtask

  // Advance n cycles, sampling 1 ns after each rising edge (DUT uses falling edge).
  task automatic cyc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ram_we_lo) ram_lo_cnt++;
      if (ram_we_hi) ram_hi_cnt++;
      if (ram_we_lo && ram_we_hi) ram_both_cnt++;
      if (ram_we_lo || ram_we_hi) ram_dati_seen = ram_mem_dati;
      if (rom_we_lo || rom_we_hi) rom_pulse_cnt++;
      rom_dati_or |= rom_mem_dati;
    end
  endtask

  task automatic bus_idle();
    cpu_ce_n = 1'b1; cpu_oe_n = 1'b1; cpu_we_lo_n = 1'b1; cpu_we_hi_n = 1'b1;
  endtask

  // Measures cycles from sel rising to rd_valid rising, then sel falling to rd_valid falling.
  task automatic lat_seq(input string name, input logic is_ram,
                         input logic [22:0] addr, input int exp_lat);
    int t_sel, t_val, t_off, t_voff;
    logic s, v;
    t_sel = -1; t_val = -1; t_off = -1; t_voff = -1;
    bus_idle();
    cyc(6);
    cpu_addr = addr; cpu_ce_n = 1'b0; cpu_oe_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      s = is_ram ? ram_sel : rom_sel;
      v = is_ram ? ram_rd_valid : rom_rd_valid;
      if (s && t_sel < 0) t_sel = i;
      if (v && t_val < 0) t_val = i;
    end
    chk({name, "_sel_delay"}, 32'(t_sel), 32'd2);
    chk({name, "_rd_lat"}, 32'(t_val - t_sel), 32'(exp_lat));
    chk({name, "_rd_data"}, 32'(is_ram ? ram_rd_data : rom_rd_data),
        is_ram ? 32'h5AA5 : 32'hA55A);
    cpu_oe_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      s = is_ram ? ram_sel : rom_sel;
      v = is_ram ? ram_rd_valid : rom_rd_valid;
      if (!s && t_off < 0) t_off = i;
      if (!v && t_voff < 0) t_voff = i;
    end
    chk({name, "_valid_clear"}, 32'(t_voff - t_off), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [22:0] addr;
    logic        ce_n;
    logic        oe_n;
    logic        rom_sel;
    logic        ram_sel;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"idle",         23'h000100, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"rom_read",     23'h000100, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"ram_read",     23'h200000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"ce_off",       23'h000100, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"ram_top",      23'h7FFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{"rom_top",      23'h1FFFFF, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset with every strobe active.
    rst = 1'b1;
    cpu_addr = 23'h200000; cpu_data = 16'h1234;
    cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_we_lo_n = 1'b0; cpu_we_hi_n = 1'b0;
    clear_counts();
    cyc(3);
    chk("rst_ram_sel",   32'(ram_sel), 32'd0);
    chk("rst_ram_oe",    32'(ram_mem_oe), 32'd0);
    chk("rst_ram_valid", 32'(ram_rd_valid), 32'd0);
    chk("rst_ram_addr",  32'(ram_mem_addr), 32'd0);
    chk("rst_ram_dati",  32'(ram_mem_dati), 32'd0);
    chk("rst_ram_we",    32'({ram_we_hi, ram_we_lo}), 32'd0);
    chk("rst_rom_sel",   32'(rom_sel), 32'd0);
    chk("rst_rom_rdata", 32'(rom_rd_data), 32'd0);
    rst = 1'b0;
    clear_counts();
    cyc(8);
    chk("rel_no_pulse_lo", ram_lo_cnt, 0);
    chk("rel_no_pulse_hi", ram_hi_cnt, 0);
    chk("rel_read_sel", 32'(ram_sel), 32'd1);
    bus_idle();
    cyc(6);

    // Steady-state read / window decode table.
    foreach (vecs[i]) begin
      cpu_addr = vecs[i].addr; cpu_ce_n = vecs[i].ce_n; cpu_oe_n = vecs[i].oe_n;
      cyc(6);
      chk({vecs[i].name, "_rom_sel"},   32'(rom_sel), 32'(vecs[i].rom_sel));
      chk({vecs[i].name, "_rom_oe"},    32'(rom_mem_oe), 32'(vecs[i].rom_sel));
      chk({vecs[i].name, "_rom_valid"}, 32'(rom_rd_valid), 32'(vecs[i].rom_sel));
      chk({vecs[i].name, "_ram_sel"},   32'(ram_sel), 32'(vecs[i].ram_sel));
      chk({vecs[i].name, "_ram_valid"}, 32'(ram_rd_valid), 32'(vecs[i].ram_sel));
      chk({vecs[i].name, "_rom_addr"},  32'(rom_mem_addr), 32'(vecs[i].addr));
      chk({vecs[i].name, "_ram_addr"},  32'(ram_mem_addr), 32'(vecs[i].addr));
      if (vecs[i].rom_sel) chk({vecs[i].name, "_rom_data"}, 32'(rom_rd_data), 32'hA55A);
      if (vecs[i].ram_sel) chk({vecs[i].name, "_ram_data"}, 32'(ram_rd_data), 32'h5AA5);
    end

    lat_seq("rom", 1'b0, 23'h000100, 2);
    lat_seq("ram", 1'b1, 23'h200100, 1);

    // Byte write held low for 10 cycles.
    bus_idle(); cyc(4);
    clear_counts();
    cpu_addr = 23'h200010; cpu_data = 16'h12EF; cpu_ce_n = 1'b0; cpu_we_lo_n = 1'b0;
    cyc(10);
    bus_idle(); cyc(4);
    chk("byte_lo_pulses", ram_lo_cnt, 1);
    chk("byte_hi_pulses", ram_hi_cnt, 0);
    chk("byte_dati",      32'(ram_dati_seen), 32'h12EF);
    chk("byte_rom_quiet", rom_pulse_cnt, 0);

    // Word write inside the RAM window.
    clear_counts();
    cpu_addr = 23'h200020; cpu_data = 16'hC3D4; cpu_ce_n = 1'b0;
    cpu_we_lo_n = 1'b0; cpu_we_hi_n = 1'b0;
    cyc(8);
    bus_idle(); cyc(4);
    chk("word_lo_pulses", ram_lo_cnt, 1);
    chk("word_hi_pulses", ram_hi_cnt, 1);
    chk("word_same_cycle", ram_both_cnt, 1);
    chk("word_dati", 32'(ram_dati_seen), 32'hC3D4);

    // Word write inside the ROM window: read-only port and RAM miss both stay silent.
    clear_counts();
    cpu_addr = 23'h000020; cpu_data = 16'h7E81; cpu_ce_n = 1'b0;
    cpu_we_lo_n = 1'b0; cpu_we_hi_n = 1'b0;
    cyc(8);
    bus_idle(); cyc(4);
    chk("ro_rom_pulses", rom_pulse_cnt, 0);
    chk("ro_rom_dati",   32'(rom_dati_or), 32'd0);
    chk("miss_ram_pulses", ram_lo_cnt + ram_hi_cnt, 0);

    // Two separate low-byte strobes give two pulses.
    clear_counts();
    cpu_addr = 23'h200040; cpu_data = 16'h0F0F; cpu_ce_n = 1'b0;
    cpu_we_lo_n = 1'b0; cyc(4);
    cpu_we_lo_n = 1'b1; cyc(2);
    cpu_we_lo_n = 1'b0; cyc(4);
    bus_idle(); cyc(4);
    chk("rewrite_pulses", ram_lo_cnt, 2);

    // Async reset during a valid read plus a pending write.
    cpu_addr = 23'h200030; cpu_data = 16'hBEEF; cpu_ce_n = 1'b0; cpu_oe_n = 1'b0;
    cyc(6);
    chk("pre_rst_valid", 32'(ram_rd_valid), 32'd1);
    cpu_we_lo_n = 1'b0;
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sel",   32'(ram_sel), 32'd0);
    chk("mid_rst_oe",    32'(ram_mem_oe), 32'd0);
    chk("mid_rst_valid", 32'(ram_rd_valid), 32'd0);
    chk("mid_rst_addr",  32'(ram_mem_addr), 32'd0);
    chk("mid_rst_we",    32'(ram_we_lo), 32'd0);
    cyc(2);
    rst = 1'b0;
    clear_counts();
    cyc(8);
    chk("post_rst_no_pulse", ram_lo_cnt, 0);
    chk("post_rst_sel", 32'(ram_sel), 32'd1);
    cpu_we_lo_n = 1'b1; cyc(3);
    cpu_we_lo_n = 1'b0; cyc(6);
    chk("post_rst_new_pulse", ram_lo_cnt, 1);
    chk("post_rst_dati", 32'(ram_dati_seen), 32'hBEEF);
    bus_idle(); cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
